regfile_context_engine: RTL and testbench

REGFILE_CONTEXT_ENGINE -- requirements
Module: regfile_context_engine

---
 rtl/regfile_context_engine_if.sv | 29 ++
 rtl/regfile_context_engine.sv | 115 +++++++++++
 tb/tb_regfile_context_engine.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_context_engine_if.sv
// Bundle of the command, register-file and stream signals of the context engine.
// The engine attaches through the master modport; the environment through slave.
interface regfile_context_engine_if;
  logic        cmd_save;
  logic        cmd_restore;
  logic        busy;
  logic        done;
  logic [4:0]  ra;
  logic [31:0] busa;
  logic [4:0]  rw;
  logic [31:0] busw;
  logic        write;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport master (
    input  cmd_save, cmd_restore, busa, out_ready, in_data, in_valid,
    output busy, done, ra, rw, busw, write, out_data, out_valid, in_ready
  );

  modport slave (
    output cmd_save, cmd_restore, busa, out_ready, in_data, in_valid,
    input  busy, done, ra, rw, busw, write, out_data, out_valid, in_ready
  );
endinterface

// File: rtl/regfile_context_engine.sv
// Register-file context engine: streams r[FIRST_REG..LAST_REG] out on a save
// command and writes an incoming stream back into the same range on restore.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for cmd_save / cmd_restore (save wins if both)
// SAVE_RD | read r[idx] via ra/busa into the output holding register
// SAVE_TX | out_valid held until the sink takes the word
// RESTORE | in_ready high, one accepted beat writes r[idx] next cycle
// DONE    | one-cycle done pulse, then back to IDLE
module regfile_context_engine #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_context_engine_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAVE_RD = 3'd1,
    SAVE_TX = 3'd2,
    RESTORE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  state_t      state_q;
  logic [4:0]  idx_q;
  logic [4:0]  idx_d;
  logic        idx_last;
  logic [31:0] out_data_q;
  logic        out_valid_q;
  logic        write_q;
  logic [4:0]  rw_q;
  logic [31:0] busw_q;

  // Next index saturates at LAST_IDX so the counter can never wrap.
  assign idx_last = (idx_q == LAST_IDX);
  assign idx_d    = idx_last ? idx_q : idx_q + 5'd1;

  // Sequencer: state, index and all registered bus/stream outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= FIRST_IDX;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      write_q     <= 1'b0;
      rw_q        <= '0;
      busw_q      <= '0;
    end else begin
      write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_save) begin
            idx_q   <= FIRST_IDX;
            state_q <= SAVE_RD;
          end else if (bus.cmd_restore) begin
            idx_q   <= FIRST_IDX;
            state_q <= RESTORE;
          end
        end
        SAVE_RD: begin
          out_data_q  <= bus.busa;
          out_valid_q <= 1'b1;
          state_q     <= SAVE_TX;
        end
        SAVE_TX: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_last) begin
              state_q <= DONE;
            end else begin
              idx_q   <= idx_d;
              state_q <= SAVE_RD;
            end
          end
        end
        RESTORE: begin
          if (bus.in_valid) begin
            write_q <= 1'b1;
            rw_q    <= idx_q;
            busw_q  <= bus.in_data;
            if (idx_last) begin
              state_q <= DONE;
            end else begin
              idx_q <= idx_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ra        = idx_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.in_ready  = (state_q == RESTORE);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.write     = write_q;
  assign bus.rw        = rw_q;
  assign bus.busw      = busw_q;

endmodule

// File: tb/tb_regfile_context_engine.sv
// Directed bench for regfile_context_engine: save (free-running and stalled
// sink), restore with and without a mid-stream reset, single-register range.
module tb_regfile_context_engine;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic preload = 1'b1;

  always #5 clk = ~clk;

  regfile_context_engine_if bus ();
  regfile_context_engine_if bus5 ();

  regfile_context_engine u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  regfile_context_engine #(.FIRST_REG(5), .LAST_REG(5)) u_dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5)
  );

  // Register-file model: rN = N*0x11111111 after preload, written by the DUT.
  logic [31:0] rf [32];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'(i) * 32'h1111_1111;
    end else if (bus.write) begin
      rf[bus.rw] <= bus.busw;
    end
  end

  assign bus.busa  = rf[bus.ra];
  assign bus5.busa = 32'(bus5.ra) * 32'h1111_1111;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Save run; toggle stalls the sink every other cycle, both raises cmd_restore
  // with cmd_save and again while busy.
  task automatic save_run(input bit toggle, input bit both);
    int cyc, beats, first_valid, done_cyc, stab_err, wr_err;
    logic [31:0] held;
    bit stalled;
    beats = 0; first_valid = -1; done_cyc = -1; stab_err = 0; wr_err = 0;
    held = '0; stalled = 1'b0; cyc = 0;
    @(negedge clk);
    bus.cmd_save    = 1'b1;
    bus.cmd_restore = both;
    bus.out_ready   = 1'b1;
    while (cyc < 400 && done_cyc < 0) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      bus.cmd_save    = 1'b0;
      bus.cmd_restore = both && (cyc >= 5) && (cyc <= 10);
      if (stalled && (bus.out_valid !== 1'b1 || bus.out_data !== held)) stab_err++;
      if (bus.write !== 1'b0) wr_err++;
      if (bus.out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (bus.done === 1'b1) done_cyc = cyc;
      bus.out_ready = toggle ? cyc[0] : 1'b1;
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        beats++;
        chk($sformatf("save_beat%0d", beats), bus.out_data, 32'(beats) * 32'h1111_1111);
        stalled = 1'b0;
      end else begin
        stalled = bus.out_valid;
        held    = bus.out_data;
      end
    end
    bus.cmd_restore = 1'b0;
    chk("save_beats", 32'(beats), 32'd31);
    chk("save_first_valid", 32'(first_valid), 32'd2);
    if (!toggle) chk("save_done_cycle", 32'(done_cyc), 32'd63);
    else         chk("save_done_seen", {31'd0, done_cyc > 0}, 32'd1);
    chk("save_stable", 32'(stab_err), 32'd0);
    chk("save_no_write", 32'(wr_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("save_back_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  // Restore run with continuous in_valid; abort_after>0 pulls reset low right
  // after that many beats have been accepted.
  task automatic restore_run(input logic [31:0] base, input int abort_after);
    int cyc, k, wr_err;
    bit acc, fin;
    cyc = 0; k = 0; wr_err = 0; fin = 1'b0;
    @(negedge clk);
    bus.cmd_restore = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_data     = base + 32'd1;
    while (cyc < 200 && !fin) begin
      acc = (bus.in_ready === 1'b1) && bus.in_valid;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      bus.cmd_restore = 1'b0;
      if (acc) begin
        k++;
        chk($sformatf("rst_write%0d", k), {31'd0, bus.write}, 32'd1);
        chk($sformatf("rst_rw%0d", k), {27'd0, bus.rw}, 32'(k));
        chk($sformatf("rst_busw%0d", k), bus.busw, base + 32'(k));
        bus.in_data = base + 32'(k + 1);
        if (k == 31) begin
          chk("rst_done", {31'd0, bus.done}, 32'd1);
          fin = 1'b1;
        end
        if (k == abort_after) begin
          reset = 1'b0;
          @(posedge clk);
          @(negedge clk);
          chk("abort_busy", {31'd0, bus.busy}, 32'd0);
          chk("abort_write", {31'd0, bus.write}, 32'd0);
          chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
          reset = 1'b1;
          fin = 1'b1;
        end
      end else if (bus.write !== 1'b0) begin
        wr_err++;
      end
    end
    bus.in_valid = 1'b0;
    chk("rst_no_stray_write", 32'(wr_err), 32'd0);
    chk("rst_beats", 32'(k), (abort_after > 0) ? 32'(abort_after) : 32'd31);
    @(posedge clk);
    @(negedge clk);
    chk("rst_back_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int beats5, done5, err_hi;
    bus.cmd_save = 1'b0; bus.cmd_restore = 1'b0; bus.out_ready = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0;
    bus5.cmd_save = 1'b0; bus5.cmd_restore = 1'b0; bus5.out_ready = 1'b0;
    bus5.in_data = '0; bus5.in_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_out_data", bus.out_data, 32'd0);
    chk("reset_write", {31'd0, bus.write}, 32'd0);
    chk("reset_rw", {27'd0, bus.rw}, 32'd0);
    chk("reset_busw", bus.busw, 32'd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("reset_ra", {27'd0, bus.ra}, 32'd1);
    preload = 1'b0;
    reset   = 1'b1;

    save_run(1'b0, 1'b1);
    save_run(1'b1, 1'b0);

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("idle_no_write", {31'd0, bus.write}, 32'd0);
    bus.in_valid = 1'b0;

    restore_run(32'hA000_0000, 0);
    chk("rb_r0", rf[0], 32'd0);
    chk("rb_r1", rf[1], 32'hA000_0001);
    chk("rb_r16", rf[16], 32'hA000_0010);
    chk("rb_r31", rf[31], 32'hA000_001F);

    restore_run(32'hB000_0000, 10);
    chk("abort_r10", rf[10], 32'hB000_000A);
    err_hi = 0;
    for (int i = 11; i < 32; i++) if (rf[i] !== 32'hA000_0000 + 32'(i)) err_hi++;
    chk("abort_r11_r31_kept", 32'(err_hi), 32'd0);

    beats5 = 0; done5 = -1;
    @(negedge clk);
    bus5.cmd_save  = 1'b1;
    bus5.out_ready = 1'b1;
    for (int c = 1; c <= 20 && done5 < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      bus5.cmd_save = 1'b0;
      if (bus5.done === 1'b1) done5 = c;
      if (bus5.out_valid === 1'b1) begin
        beats5++;
        chk("r5_data", bus5.out_data, 32'h5555_5555);
      end
    end
    chk("r5_beats", 32'(beats5), 32'd1);
    chk("r5_done_cycle", 32'(done5), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
